// File: rtl/trig_pattern_gen.sv
// trig_pattern_gen: A-B-C trigger pulse pattern generator driving three packed two-sample ADC-style streams.
// Optional feature: define TRIG_PATTERN_NOISE_EN to XOR 16-bit LFSR dither into every output sample.
module trig_pattern_gen #(
  parameter int ADC_DATA_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          gen_enable,
  input  logic                          start,
  input  logic [31:0]                   cfg_delay_ab,
  input  logic [31:0]                   cfg_delay_bc,
  input  logic [15:0]                   cfg_width,
  input  logic [ADC_DATA_WIDTH-1:0]     cfg_amp_a,
  input  logic [ADC_DATA_WIDTH-1:0]     cfg_amp_b,
  input  logic [ADC_DATA_WIDTH-1:0]     cfg_amp_c,
  input  logic [ADC_DATA_WIDTH-1:0]     cfg_baseline,
  output logic [2*ADC_DATA_WIDTH-1:0]   adc_data_a,
  output logic [2*ADC_DATA_WIDTH-1:0]   adc_data_b,
  output logic [2*ADC_DATA_WIDTH-1:0]   adc_data_c,
  output logic                          adc_valid_a,
  output logic                          adc_valid_b,
  output logic                          adc_valid_c,
  output logic                          adc_enable_a,
  output logic                          adc_enable_b,
  output logic                          adc_enable_c,
  output logic                          busy,
  output logic                          done,
  output logic [31:0]                   seq_count
);
  typedef enum logic [2:0] {IDLE, PULSE_A, GAP_AB, PULSE_B, GAP_BC, PULSE_C} state_t;
  state_t state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] lat_dab, lat_dbc;
  logic [15:0] lat_width;
  logic [ADC_DATA_WIDTH-1:0] lat_amp_a, lat_amp_b, lat_amp_c, lat_base;
  logic idle;
  logic [31:0] eff_dab, eff_dbc;
  logic [15:0] eff_width, w_m1;
  logic [ADC_DATA_WIDTH-1:0] eff_amp_a, eff_amp_b, eff_amp_c;
  logic [ADC_DATA_WIDTH-1:0] base, sa, sb, sc;
  logic [2*ADC_DATA_WIDTH-1:0] noise;
  logic [2*ADC_DATA_WIDTH-1:0] data_a_n, data_b_n, data_c_n;
  logic busy_n, done_n;
  logic [31:0] count_n;
  // Live cfg applies while idle (including the launch edge); latched cfg applies inside a sequence
  always_comb begin
    idle      = (state == IDLE);
    eff_dab   = idle ? cfg_delay_ab : lat_dab;
    eff_dbc   = idle ? cfg_delay_bc : lat_dbc;
    eff_width = idle ? cfg_width    : lat_width;
    eff_amp_a = idle ? cfg_amp_a    : lat_amp_a;
    eff_amp_b = idle ? cfg_amp_b    : lat_amp_b;
    eff_amp_c = idle ? cfg_amp_c    : lat_amp_c;
    w_m1      = (eff_width == 16'd0) ? 16'd0 : eff_width - 16'd1;
  end
  // State register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;
  // Next state and phase down-counter; counter is loaded with duration-1 on every state change
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? PULSE_A : IDLE;
      PULSE_A: state_n = (cnt != 32'd0) ? PULSE_A : (eff_dab == 32'd0) ? PULSE_B : GAP_AB;
      GAP_AB:  state_n = (cnt != 32'd0) ? GAP_AB  : PULSE_B;
      PULSE_B: state_n = (cnt != 32'd0) ? PULSE_B : (eff_dbc == 32'd0) ? PULSE_C : GAP_BC;
      GAP_BC:  state_n = (cnt != 32'd0) ? GAP_BC  : PULSE_C;
      PULSE_C: state_n = (cnt != 32'd0) ? PULSE_C : IDLE;
      default: state_n = IDLE;
    endcase
    if (!gen_enable) state_n = IDLE;
    cnt_n = (state_n == IDLE)    ? 32'd0 :
            (state_n == state)   ? cnt - 32'd1 :
            (state_n == GAP_AB)  ? eff_dab - 32'd1 :
            (state_n == GAP_BC)  ? eff_dbc - 32'd1 : {16'd0, w_m1};
  end
  // Counter and sequence configuration snapshot taken on the launch edge
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt       <= '0;
      lat_dab   <= '0;
      lat_dbc   <= '0;
      lat_width <= '0;
      lat_amp_a <= '0;
      lat_amp_b <= '0;
      lat_amp_c <= '0;
      lat_base  <= '0;
    end else begin
      cnt <= cnt_n;
      if (idle && state_n == PULSE_A) begin
        lat_dab   <= cfg_delay_ab;
        lat_dbc   <= cfg_delay_bc;
        lat_width <= cfg_width;
        lat_amp_a <= cfg_amp_a;
        lat_amp_b <= cfg_amp_b;
        lat_amp_c <= cfg_amp_c;
        lat_base  <= cfg_baseline;
      end
    end
`ifdef TRIG_PATTERN_NOISE_EN
  logic [15:0] lfsr;
  // Dither LFSR advances every clock and restarts from its seed on reset
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign noise = {{(ADC_DATA_WIDTH-2){1'b0}}, lfsr[3:2], {(ADC_DATA_WIDTH-2){1'b0}}, lfsr[1:0]};
`else
  assign noise = '0;
`endif
  // Output values computed from the next state so the registered outputs line up with the state register
  always_comb begin
    base     = (idle || state_n == IDLE) ? cfg_baseline : lat_base;
    sa       = (state_n == PULSE_A) ? eff_amp_a : base;
    sb       = (state_n == PULSE_B) ? eff_amp_b : base;
    sc       = (state_n == PULSE_C) ? eff_amp_c : base;
    data_a_n = {sa, sa} ^ noise;
    data_b_n = {sb, sb} ^ noise;
    data_c_n = {sc, sc} ^ noise;
    busy_n   = (state_n != IDLE);
    done_n   = (state == PULSE_C) && (cnt == 32'd0) && gen_enable;
    count_n  = seq_count + {31'd0, done_n};
  end
  // Registered outputs
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      adc_data_a   <= '0;
      adc_data_b   <= '0;
      adc_data_c   <= '0;
      adc_valid_a  <= 1'b0;
      adc_valid_b  <= 1'b0;
      adc_valid_c  <= 1'b0;
      adc_enable_a <= 1'b0;
      adc_enable_b <= 1'b0;
      adc_enable_c <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      seq_count    <= '0;
    end else begin
      adc_data_a   <= data_a_n;
      adc_data_b   <= data_b_n;
      adc_data_c   <= data_c_n;
      adc_valid_a  <= gen_enable;
      adc_valid_b  <= gen_enable;
      adc_valid_c  <= gen_enable;
      adc_enable_a <= 1'b1;
      adc_enable_b <= 1'b1;
      adc_enable_c <= 1'b1;
      busy         <= busy_n;
      done         <= done_n;
      seq_count    <= count_n;
    end
endmodule

// File: tb/tb_trig_pattern_gen.sv
// tb_trig_pattern_gen: scoreboard bench; stimulus queues expected per-channel change events, a monitor pops and compares them.
module tb_trig_pattern_gen;
  logic clk = 1'b0, resetn = 1'b0, gen_enable = 1'b1, start = 1'b0;
  logic [31:0] cfg_delay_ab = '0, cfg_delay_bc = '0;
  logic [15:0] cfg_width = '0, cfg_amp_a = '0, cfg_amp_b = '0, cfg_amp_c = '0, cfg_baseline = 16'h0010;
  logic [31:0] adc_data_a, adc_data_b, adc_data_c, seq_count;
  logic adc_valid_a, adc_valid_b, adc_valid_c, adc_enable_a, adc_enable_b, adc_enable_c, busy, done;
  trig_pattern_gen #(.ADC_DATA_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .gen_enable(gen_enable), .start(start),
    .cfg_delay_ab(cfg_delay_ab), .cfg_delay_bc(cfg_delay_bc), .cfg_width(cfg_width),
    .cfg_amp_a(cfg_amp_a), .cfg_amp_b(cfg_amp_b), .cfg_amp_c(cfg_amp_c), .cfg_baseline(cfg_baseline),
    .adc_data_a(adc_data_a), .adc_data_b(adc_data_b), .adc_data_c(adc_data_c),
    .adc_valid_a(adc_valid_a), .adc_valid_b(adc_valid_b), .adc_valid_c(adc_valid_c),
    .adc_enable_a(adc_enable_a), .adc_enable_b(adc_enable_b), .adc_enable_c(adc_enable_c),
    .busy(busy), .done(done), .seq_count(seq_count)
  );
  always #4 clk = ~clk;
  typedef struct {int cyc; logic [31:0] val;} ev_t;
  ev_t qa[$], qb[$], qc[$], qd[$];
  int checks = 0, failures = 0, ncyc = 0;
  bit mon_en = 1'b0;
  logic [31:0] pa = '0, pb = '0, pc = '0;
  logic pd = 1'b0;
  always @(posedge clk) ncyc <= ncyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask
  task automatic push(input int ch, input int c, input logic [31:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    if (ch == 0) qa.push_back(e);
    else if (ch == 1) qb.push_back(e);
    else if (ch == 2) qc.push_back(e);
    else qd.push_back(e);
  endtask
  task automatic push_seq(input int l, input int w, input int dab, input int dbc,
                          input logic [15:0] aa, input logic [15:0] ab, input logic [15:0] ac,
                          input logic [15:0] bl, input logic [15:0] be, input logic [31:0] cnt);
    int ce;
    ce = l + 3*w + dab + dbc;
    push(0, l, {aa, aa});
    push(0, l + w, {bl, bl});
    push(1, l + w + dab, {ab, ab});
    push(1, l + 2*w + dab, {bl, bl});
    push(2, l + 2*w + dab + dbc, {ac, ac});
    push(2, ce, {be, be});
    if (be !== bl) begin
      push(0, ce, {be, be});
      push(1, ce, {be, be});
    end
    push(3, ce, cnt);
  endtask
  task automatic check_ev(input int ch, input string nm, input logic [31:0] act);
    ev_t e;
    bit have;
    have = 1'b0;
    if (ch == 0 && qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
    else if (ch == 1 && qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
    else if (ch == 2 && qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
    else if (ch == 3 && qd.size() > 0) begin e = qd.pop_front(); have = 1'b1; end
    checks++;
    if (!have) begin
      failures++;
      $display("FAIL %s: unexpected event value %h at cycle %0d", nm, act, ncyc);
    end else if (e.cyc != ncyc || e.val !== act) begin
      failures++;
      $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d", nm, act, ncyc, e.val, e.cyc);
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      if (adc_data_a !== pa) check_ev(0, "data_a", adc_data_a);
      if (adc_data_b !== pb) check_ev(1, "data_b", adc_data_b);
      if (adc_data_c !== pc) check_ev(2, "data_c", adc_data_c);
      if (done && !pd) check_ev(3, "done_count", seq_count);
      if (done && pd) chk("done_width", {31'd0, done}, 32'd0);
    end
    pa <= adc_data_a;
    pb <= adc_data_b;
    pc <= adc_data_c;
    pd <= done;
  end
  task automatic tick;
    @(negedge clk);
    #1;
  endtask
  task automatic wait_until(input int c);
    while (ncyc < c) tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int l, l2, l3;
    tick();
    chk("rst_data_a", adc_data_a, 32'h0);
    chk("rst_data_c", adc_data_c, 32'h0);
    chk("rst_valid", {31'd0, adc_valid_a}, 32'd0);
    chk("rst_enable", {31'd0, adc_enable_b}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", seq_count, 32'd0);
    resetn = 1'b1;
    tick();
    chk("init_data_a", adc_data_a, 32'h0010_0010);
    chk("init_data_b", adc_data_b, 32'h0010_0010);
    chk("init_data_c", adc_data_c, 32'h0010_0010);
    chk("init_valid", {31'd0, adc_valid_c}, 32'd1);
    chk("init_enable", {31'd0, adc_enable_a}, 32'd1);
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_count", seq_count, 32'd0);
    mon_en = 1'b1;
    tick();
    cfg_width = 16'd4; cfg_delay_ab = 32'd10; cfg_delay_bc = 32'd20;
    cfg_amp_a = 16'h1000; cfg_amp_b = 16'hF000; cfg_amp_c = 16'h0800;
    start = 1'b1;
    l = ncyc + 1;
    push_seq(l, 4, 10, 20, 16'h1000, 16'hF000, 16'h0800, 16'h0010, 16'h0020, 32'd1);
    tick();
    start = 1'b0;
    wait_until(l + 6);
    chk("busy_gap", {31'd0, busy}, 32'd1);
    cfg_baseline = 16'h0020; cfg_width = 16'd7; cfg_amp_a = 16'h1234; cfg_amp_b = 16'h4321; cfg_delay_bc = 32'd1;
    wait_until(l + 45);
    chk("t1_count", seq_count, 32'd1);
    cfg_width = 16'd0; cfg_delay_ab = 32'd0; cfg_delay_bc = 32'd0;
    cfg_amp_a = 16'h1111; cfg_amp_b = 16'h2222; cfg_amp_c = 16'h3333;
    start = 1'b1;
    l = ncyc + 1;
    push_seq(l, 1, 0, 0, 16'h1111, 16'h2222, 16'h3333, 16'h0020, 16'h0020, 32'd2);
    tick();
    start = 1'b0;
    wait_until(l + 6);
    cfg_width = 16'd2; cfg_delay_ab = 32'd5; cfg_delay_bc = 32'd3;
    cfg_amp_a = 16'h0A0A; cfg_amp_b = 16'hF5F5; cfg_amp_c = 16'h0505;
    start = 1'b1;
    l = ncyc + 1;
    push(0, l, 32'h0A0A_0A0A);
    push(0, l + 2, 32'h0020_0020);
    tick();
    start = 1'b0;
    wait_until(l + 3);
    gen_enable = 1'b0;
    tick();
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, adc_valid_b}, 32'd0);
    wait_until(l + 14);
    chk("abort_count", seq_count, 32'd2);
    chk("abort_done", {31'd0, done}, 32'd0);
    gen_enable = 1'b1;
    tick();
    tick();
    cfg_width = 16'd3; cfg_delay_ab = 32'd2; cfg_delay_bc = 32'd1;
    cfg_amp_a = 16'h0111; cfg_amp_b = 16'hFEEE; cfg_amp_c = 16'h0222;
    start = 1'b1;
    l = ncyc + 1;
    l2 = l + 13;
    l3 = l2 + 7;
    push_seq(l, 3, 2, 1, 16'h0111, 16'hFEEE, 16'h0222, 16'h0020, 16'h0020, 32'd3);
    push_seq(l2, 1, 2, 1, 16'h0111, 16'hFEEE, 16'h0222, 16'h0020, 16'h0020, 32'd4);
    push_seq(l3, 1, 2, 1, 16'h0111, 16'hFEEE, 16'h0222, 16'h0020, 16'h0020, 32'd5);
    wait_until(l + 1);
    cfg_width = 16'd1;
    wait_until(l3);
    start = 1'b0;
    wait_until(l3 + 8);
    chk("b2b_count", seq_count, 32'd5);
    chk("qa_left", qa.size(), 32'd0);
    chk("qb_left", qb.size(), 32'd0);
    chk("qc_left", qc.size(), 32'd0);
    chk("qd_left", qd.size(), 32'd0);
    mon_en = 1'b0;
    cfg_width = 16'd4; cfg_delay_ab = 32'd2; cfg_delay_bc = 32'd2;
    cfg_amp_a = 16'h0700; cfg_amp_b = 16'h8800; cfg_amp_c = 16'h0900;
    start = 1'b1;
    l = ncyc + 1;
    tick();
    start = 1'b0;
    wait_until(l + 7);
    chk("pulse_b_data", adc_data_b, 32'h8800_8800);
    chk("pulse_b_busy", {31'd0, busy}, 32'd1);
    resetn = 1'b0;
    #1;
    chk("async_data_a", adc_data_a, 32'h0);
    chk("async_data_b", adc_data_b, 32'h0);
    chk("async_data_c", adc_data_c, 32'h0);
    chk("async_valid", {31'd0, adc_valid_a}, 32'd0);
    chk("async_enable", {31'd0, adc_enable_c}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_count", seq_count, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    chk("rel_data_a", adc_data_a, 32'h0020_0020);
    chk("rel_data_c", adc_data_c, 32'h0020_0020);
    chk("rel_enable", {31'd0, adc_enable_b}, 32'd1);
    chk("rel_valid", {31'd0, adc_valid_b}, 32'd1);
    tick();
    tick();
    chk("rel_busy", {31'd0, busy}, 32'd0);
    chk("rel_count", seq_count, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
